// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: states, opcodes,
// instruction classes and the pc_src / alu_op select values.
package mips_pkg;

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_HALT      = 3'd1,
      ST_FETCH     = 3'd2,
      ST_DECODE    = 3'd3,
      ST_EXECUTE   = 3'd4,
      ST_MEMORY    = 3'd5,
      ST_WRITEBACK = 3'd6,
      ST_TRAP      = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      CL_NONE = 3'd0,
      CL_ADD  = 3'd1,
      CL_SUB  = 3'd2,
      CL_ADDI = 3'd3,
      CL_BEQ  = 3'd4,
      CL_J    = 3'd5,
      CL_LW   = 3'd6,
      CL_SW   = 3'd7
   } iclass_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;

   localparam logic [1:0] PC_INC    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_PASSA = 2'd2;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational opcode/funct classifier; anything outside the supported
// instruction set reports illegal with class NONE.
module mips_ctrl_decode
   import mips_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic [OP_W-1:0] dec_opcode_i,
   input  logic [OP_W-1:0] dec_funct_i,
   output iclass_e         dec_class_o,
   output logic            dec_illegal_o
);

   always_comb begin
      dec_class_o   = CL_NONE;
      dec_illegal_o = 1'b0;
      case (dec_opcode_i)
         OP_W'(OP_RTYPE): begin
            if (dec_funct_i == OP_W'(FN_ADD))      dec_class_o = CL_ADD;
            else if (dec_funct_i == OP_W'(FN_SUB)) dec_class_o = CL_SUB;
            else                                   dec_illegal_o = 1'b1;
         end
         OP_W'(OP_ADDI): dec_class_o = CL_ADDI;
         OP_W'(OP_BEQ):  dec_class_o = CL_BEQ;
         OP_W'(OP_J):    dec_class_o = CL_J;
         OP_W'(OP_LW):   dec_class_o = CL_LW;
         OP_W'(OP_SW):   dec_class_o = CL_SW;
         default:        dec_illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_multi_ctrl.sv
// Main control sequencer for the multicycle MIPS datapath: state register,
// Moore-style strobe decode, latched instruction class and retired counter.
module mips_multi_ctrl
   import mips_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int OP_W  = 6
) (
   input  logic             ctrl_in_clk,
   input  logic             ctrl_in_rst_n,
   input  logic             ctrl_in_run,
   input  logic [OP_W-1:0]  ctrl_in_opcode,
   input  logic [OP_W-1:0]  ctrl_in_funct,
   input  logic             ctrl_in_zero,
   input  logic             ctrl_in_mem_ready,
   output logic [2:0]       ctrl_out_state,
   output logic             ctrl_out_pc_write,
   output logic [1:0]       ctrl_out_pc_src,
   output logic             ctrl_out_ir_write,
   output logic             ctrl_out_ab_write,
   output logic [1:0]       ctrl_out_alu_op,
   output logic             ctrl_out_alu_src_imm,
   output logic             ctrl_out_mem_wren,
   output logic             ctrl_out_reg_write,
   output logic             ctrl_out_reg_dst_rt,
   output logic             ctrl_out_mem_to_reg,
   output logic             ctrl_out_trap,
   output logic [CNT_W-1:0] ctrl_out_retired
);

   state_e           state_q, state_d;
   iclass_e          class_q, class_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             retire;
   iclass_e          dec_class;
   logic             dec_illegal;

   mips_ctrl_decode #(.OP_W(OP_W)) u_decode (
      .dec_opcode_i  (ctrl_in_opcode),
      .dec_funct_i   (ctrl_in_funct),
      .dec_class_o   (dec_class),
      .dec_illegal_o (dec_illegal)
   );

   always_ff @(posedge ctrl_in_clk or negedge ctrl_in_rst_n) begin
      if (!ctrl_in_rst_n) begin
         state_q   <= ST_RESET;
         class_q   <= CL_NONE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      state_d              = state_q;
      class_d              = class_q;
      retire               = 1'b0;
      ctrl_out_pc_write    = 1'b0;
      ctrl_out_pc_src      = PC_INC;
      ctrl_out_ir_write    = 1'b0;
      ctrl_out_ab_write    = 1'b0;
      ctrl_out_alu_op      = ALU_ADD;
      ctrl_out_alu_src_imm = 1'b0;
      ctrl_out_mem_wren    = 1'b0;
      ctrl_out_reg_write   = 1'b0;
      ctrl_out_reg_dst_rt  = 1'b0;
      ctrl_out_mem_to_reg  = 1'b0;
      ctrl_out_trap        = 1'b0;
      case (state_q)
         ST_RESET: state_d = ST_HALT;
         ST_HALT: begin
            if (ctrl_in_run) state_d = ST_FETCH;
         end
         // run is sampled only here, so a dropped run lets the current instruction finish
         ST_FETCH: begin
            if (!ctrl_in_run) begin
               state_d = ST_HALT;
            end else begin
               ctrl_out_ir_write = 1'b1;
               ctrl_out_pc_write = 1'b1;
               ctrl_out_pc_src   = PC_INC;
               state_d           = ST_DECODE;
            end
         end
         ST_DECODE: begin
            ctrl_out_ab_write = 1'b1;
            class_d           = dec_class;
            if (dec_illegal) begin
               state_d = ST_TRAP;
            end else if (dec_class == CL_J) begin
               ctrl_out_pc_write = 1'b1;
               ctrl_out_pc_src   = PC_JUMP;
               retire            = 1'b1;
               state_d           = ST_FETCH;
            end else begin
               state_d = ST_EXECUTE;
            end
         end
         ST_EXECUTE: begin
            case (class_q)
               CL_ADD: state_d = ST_WRITEBACK;
               CL_SUB: begin
                  ctrl_out_alu_op = ALU_SUB;
                  state_d         = ST_WRITEBACK;
               end
               CL_ADDI: begin
                  ctrl_out_alu_src_imm = 1'b1;
                  state_d              = ST_WRITEBACK;
               end
               CL_LW, CL_SW: begin
                  ctrl_out_alu_src_imm = 1'b1;
                  state_d              = ST_MEMORY;
               end
               CL_BEQ: begin
                  ctrl_out_alu_op   = ALU_SUB;
                  ctrl_out_pc_write = ctrl_in_zero;
                  ctrl_out_pc_src   = PC_BRANCH;
                  retire            = 1'b1;
                  state_d           = ST_FETCH;
               end
               default: state_d = ST_TRAP;
            endcase
         end
         ST_MEMORY: begin
            ctrl_out_mem_wren = (class_q == CL_SW);
            if (ctrl_in_mem_ready) begin
               if (class_q == CL_SW) begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WRITEBACK;
               end
            end
         end
         ST_WRITEBACK: begin
            ctrl_out_reg_write  = 1'b1;
            ctrl_out_reg_dst_rt = (class_q == CL_ADDI) || (class_q == CL_LW);
            ctrl_out_mem_to_reg = (class_q == CL_LW);
            retire              = 1'b1;
            state_d             = ST_FETCH;
         end
         ST_TRAP: ctrl_out_trap = 1'b1;
         default: state_d = ST_RESET;
      endcase
   end

   // Saturating count: holds at all-ones instead of wrapping
   always_comb begin
      retired_d = retired_q;
      if (retire && (retired_q != {CNT_W{1'b1}})) retired_d = retired_q + 1'b1;
   end

   assign ctrl_out_state   = state_q;
   assign ctrl_out_retired = retired_q;

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Randomized self-checking bench for mips_multi_ctrl: a per-instruction
// cycle-trace model built from the class table is compared every cycle.
module tb_mips_multi_ctrl;

   localparam int CNT_W = 8;
   localparam int OP_W  = 6;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             run = 1'b0;
   logic [OP_W-1:0]  opcode = '0;
   logic [OP_W-1:0]  funct = '0;
   logic             zero = 1'b0;
   logic             mem_ready = 1'b0;
   logic [2:0]       state;
   logic             pc_write, ir_write, ab_write, alu_src_imm, mem_wren;
   logic             reg_write, reg_dst_rt, mem_to_reg, trap;
   logic [1:0]       pc_src, alu_op;
   logic [CNT_W-1:0] retired;

   mips_multi_ctrl #(.CNT_W(CNT_W), .OP_W(OP_W)) dut (
      .ctrl_in_clk          (clk),
      .ctrl_in_rst_n        (rst_n),
      .ctrl_in_run          (run),
      .ctrl_in_opcode       (opcode),
      .ctrl_in_funct        (funct),
      .ctrl_in_zero         (zero),
      .ctrl_in_mem_ready    (mem_ready),
      .ctrl_out_state       (state),
      .ctrl_out_pc_write    (pc_write),
      .ctrl_out_pc_src      (pc_src),
      .ctrl_out_ir_write    (ir_write),
      .ctrl_out_ab_write    (ab_write),
      .ctrl_out_alu_op      (alu_op),
      .ctrl_out_alu_src_imm (alu_src_imm),
      .ctrl_out_mem_wren    (mem_wren),
      .ctrl_out_reg_write   (reg_write),
      .ctrl_out_reg_dst_rt  (reg_dst_rt),
      .ctrl_out_mem_to_reg  (mem_to_reg),
      .ctrl_out_trap        (trap),
      .ctrl_out_retired     (retired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       pcw;
      logic [1:0] pcs;
      logic       irw;
      logic       abw;
      logic [1:0] aop;
      logic       imm;
      logic       wren;
      logic       regw;
      logic       dst;
      logic       m2r;
      logic       trp;
   } obs_t;

   obs_t act;
   assign act = {state, pc_write, pc_src, ir_write, ab_write, alu_op, alu_src_imm,
                 mem_wren, reg_write, reg_dst_rt, mem_to_reg, trap};

   int   n_tests = 0;
   int   n_fail  = 0;
   int   ret_model = 0;
   obs_t exp_q[$];
   bit   rdy_q[$];

   function automatic obs_t mk(input int st);
      obs_t o;
      o    = '0;
      o.st = 3'(st);
      return o;
   endfunction

   // 0 ADD, 1 SUB, 2 ADDI, 3 BEQ, 4 J, 5 LW, 6 SW, -1 illegal
   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00:   return (fn == 6'h20) ? 0 : (fn == 6'h22) ? 1 : -1;
         6'h08:   return 2;
         6'h04:   return 3;
         6'h02:   return 4;
         6'h23:   return 5;
         6'h2B:   return 6;
         default: return -1;
      endcase
   endfunction

   task automatic push(input obs_t o, input bit rdy);
      exp_q.push_back(o);
      rdy_q.push_back(rdy);
   endtask

   // Expected per-cycle outputs for one instruction starting at FETCH.
   task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int waits);
      int   c;
      obs_t o;
      c = classify(op, fn);
      exp_q.delete();
      rdy_q.delete();
      o = mk(2); o.irw = 1; o.pcw = 1; o.pcs = 0;
      push(o, 1'($urandom_range(1)));
      o = mk(3); o.abw = 1;
      if (c == 4) begin o.pcw = 1; o.pcs = 2; end
      push(o, 1'($urandom_range(1)));
      if (c == 4 || c < 0) return;
      o = mk(4);
      case (c)
         1:       o.aop = 1;
         2, 5, 6: o.imm = 1;
         3:       begin o.aop = 1; o.pcw = z; o.pcs = 1; end
         default: ;
      endcase
      push(o, 1'($urandom_range(1)));
      if (c == 3) return;
      if (c == 5 || c == 6) begin
         for (int i = 0; i <= waits; i++) begin
            o = mk(5);
            o.wren = (c == 6);
            push(o, (i == waits));
         end
         if (c == 6) return;
      end
      o = mk(6); o.regw = 1; o.dst = (c == 2 || c == 5); o.m2r = (c == 5);
      push(o, 1'($urandom_range(1)));
   endtask

   task automatic chk(input obs_t exp, input string nm);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: outputs got %h expected %h (state got %0d expected %0d)",
                  nm, act, exp, act.st, exp.st);
      end
   endtask

   task automatic chk_ret(input string nm);
      n_tests++;
      if (retired !== CNT_W'(ret_model)) begin
         n_fail++;
         $display("FAIL %s: retired got %0d expected %0d", nm, retired, ret_model);
      end
   endtask

   // ncyc < 0 runs the whole instruction; otherwise stops after ncyc cycles.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input int waits, input bit drop_run, input int ncyc, input string nm);
      int lim;
      build(op, fn, z, waits);
      lim = (ncyc < 0) ? exp_q.size() : ncyc;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         run       = (drop_run && i > 0) ? 1'b0 : 1'b1;
         opcode    = op;
         funct     = fn;
         zero      = z;
         mem_ready = rdy_q[i];
         #1;
         chk(exp_q[i], $sformatf("%s cyc%0d", nm, i));
         if (i == 0) chk_ret({nm, " retired_at_fetch"});
      end
      if (ncyc < 0 && classify(op, fn) >= 0 && ret_model < SAT) ret_model++;
   endtask

   task automatic start_after_reset();
      @(negedge clk);
      rst_n = 1'b1;
      run   = 1'b0;
      #1 chk(mk(0), "reset_state");
      chk_ret("reset_retired");
      @(negedge clk);
      run = 1'b0;
      #1 chk(mk(1), "halt_idle");
      @(negedge clk);
      run = 1'b1;
      #1 chk(mk(1), "halt_run_request");
      ret_model = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      run   = 1'b1;
      #1 chk(mk(0), "async_reset");
      chk_ret("async_reset_retired");
      repeat (2) @(posedge clk);
      start_after_reset();
   endtask

   task automatic test_directed();
      run_instr(6'h00, 6'h20, 1'b0, 0, 1'b0, -1, "add");
      run_instr(6'h00, 6'h22, 1'b1, 0, 1'b0, -1, "sub");
      run_instr(6'h08, 6'h15, 1'b0, 0, 1'b0, -1, "addi");
      run_instr(6'h23, 6'h00, 1'b0, 3, 1'b0, -1, "lw_wait3");
      run_instr(6'h2B, 6'h00, 1'b0, 0, 1'b0, -1, "sw_ready");
      run_instr(6'h2B, 6'h00, 1'b1, 2, 1'b0, -1, "sw_wait2");
      run_instr(6'h04, 6'h00, 1'b1, 0, 1'b0, -1, "beq_taken");
      run_instr(6'h04, 6'h00, 1'b0, 0, 1'b0, -1, "beq_not_taken");
      run_instr(6'h02, 6'h3F, 1'b1, 0, 1'b0, -1, "jump");
   endtask

   task automatic test_run_drop();
      run_instr(6'h00, 6'h20, 1'b0, 0, 1'b1, -1, "add_run_drop");
      @(negedge clk);
      run = 1'b0;
      #1 chk(mk(2), "fetch_no_strobe");
      chk_ret("run_drop_retired");
      @(negedge clk);
      run = 1'b0;
      #1 chk(mk(1), "parked_halt");
      @(negedge clk);
      run = 1'b1;
      #1 chk(mk(1), "halt_resume");
   endtask

   task automatic test_random(input int n);
      logic [5:0] ops [7];
      logic [5:0] fns [7];
      int         k;
      ops = '{6'h00, 6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B};
      fns = '{6'h20, 6'h22, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
      for (int i = 0; i < n; i++) begin
         k = $urandom_range(6);
         run_instr(ops[k], (k < 2) ? fns[k] : 6'($urandom),
                   1'($urandom_range(1)), $urandom_range(4), 1'b0, -1,
                   $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_abort();
      run_instr(6'h23, 6'h00, 1'b0, 2, 1'b0, 4, "lw_abort");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk(mk(0), "abort_reset_outputs");
      ret_model = 0;
      chk_ret("abort_retired_cleared");
      repeat (2) @(posedge clk);
      start_after_reset();
   endtask

   task automatic test_trap(input logic [5:0] op, input logic [5:0] fn, input string nm);
      obs_t t;
      t = mk(7);
      t.trp = 1'b1;
      run_instr(op, fn, 1'b0, 0, 1'b0, -1, nm);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         run       = 1'($urandom_range(1));
         mem_ready = 1'($urandom_range(1));
         opcode    = 6'($urandom);
         #1 chk(t, $sformatf("%s sticky%0d", nm, i));
      end
      chk_ret({nm, " retired"});
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk(mk(0), {nm, " cleared_by_reset"});
      repeat (2) @(posedge clk);
      start_after_reset();
   endtask

   task automatic test_saturation();
      for (int i = 0; i < SAT + 6; i++)
         run_instr(6'h02, 6'h00, 1'b0, 0, 1'b0, -1, $sformatf("jsat%0d", i));
      @(negedge clk);
      run = 1'b0;
      #1 chk(mk(2), "final_fetch_halt");
      chk_ret("retired_saturated");
   endtask

   initial begin
      test_reset();
      test_directed();
      test_run_drop();
      test_random(120);
      test_abort();
      test_trap(6'h3F, 6'h00, "trap_op3f");
      test_trap(6'h00, 6'h21, "trap_bad_funct");
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_multi_ctrl.md
Name: mips_multi_ctrl

Overview:
Main control sequencer for the multicycle MIPS datapath. It decodes opcode/funct and steps through RESET, HALT, FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, plus a TRAP state. Each cycle it drives the Moore-style enables and selects for PC, IR, A/B, ALU, data memory and register file. It sits beside the datapath registers, replacing their inline state logic. It also handles data-memory wait states, run/halt control and a retired-instruction counter.

Parameters:
CNT_W, 16, width of retired-instruction counter (saturating)
OP_W, 6, opcode and funct field width

Ports:
ctrl_in_clk  in  1  datapath clock (board-divided clock)
ctrl_in_rst_n  in  1  asynchronous, active-low reset
ctrl_in_run  in  1  1 = execute; 0 = park in HALT at next instruction boundary
ctrl_in_opcode  in  OP_W  IR[31:26], valid from the DECODE cycle onward
ctrl_in_funct  in  OP_W  IR[5:0]
ctrl_in_zero  in  1  A==B comparator from datapath
ctrl_in_mem_ready  in  1  data memory access complete this cycle
ctrl_out_state  out  3  current state encoding
ctrl_out_pc_write  out  1  load PC this cycle
ctrl_out_pc_src  out  2  0=PC+1, 1=PC+1+sext(imm16), 2=IR[9:0] (jump)
ctrl_out_ir_write  out  1  load IR from instruction memory
ctrl_out_ab_write  out  1  load A/B from register file
ctrl_out_alu_op  out  2  0=add, 1=sub, 2=pass A
ctrl_out_alu_src_imm  out  1  ALU B input = sext(imm16)
ctrl_out_mem_wren  out  1  data memory write enable
ctrl_out_reg_write  out  1  register file write enable
ctrl_out_reg_dst_rt  out  1  destination = rt (1) / rd (0)
ctrl_out_mem_to_reg  out  1  write data = memory (1) / ALU (0)
ctrl_out_trap  out  1  illegal instruction, sticky
ctrl_out_retired  out  CNT_W  count of completed instructions

Behaviour:
- State encoding: RESET=0, HALT=1, FETCH=2, DECODE=3, EXECUTE=4, MEMORY=5, WRITEBACK=6, TRAP=7.
- Reset (async, rst_n=0): state=RESET, class register=NONE, retired=0, trap=0. Every output strobe is 0; pc_src=0; alu_op=0.
- RESET: all strobes 0. Next state is HALT unconditionally.
- HALT: all strobes 0. If run=1, go to FETCH; otherwise stay in HALT.
- FETCH with run=0: no strobes; go to HALT. This is the only place run is sampled after start, so run=0 mid-instruction finishes the current instruction first.
- FETCH with run=1: ir_write=1, pc_write=1, pc_src=0. Go to DECODE.
- DECODE: ab_write=1. Latch the instruction class from opcode/funct:
  - op 0x00 with funct 0x20 = ADD; funct 0x22 = SUB.
  - 0x08 = ADDI; 0x04 = BEQ; 0x02 = J; 0x23 = LW; 0x2B = SW.
  - J: additionally pc_write=1, pc_src=2, increment retired, go to FETCH.
  - Any other opcode, or op 0x00 with any other funct: go to TRAP, ab_write still 1.
  - All other classes go to EXECUTE.
- EXECUTE, by class:
  - ADD: alu_op=0, alu_src_imm=0.
  - SUB: alu_op=1, alu_src_imm=0.
  - ADDI, LW, SW: alu_op=0, alu_src_imm=1.
  - BEQ: alu_op=1, alu_src_imm=0, pc_write=zero, pc_src=1, increment retired, go to FETCH.
  - ADD, SUB, ADDI go to WRITEBACK; LW and SW go to MEMORY.
- Branch target is word-addressed: PC already holds PC+1, so target = PC + sext(imm16). There is no +4.
- MEMORY:
  - SW: mem_wren=1 every cycle until mem_ready=1. On the ready cycle, increment retired and go to FETCH.
  - LW: mem_wren=0; wait for mem_ready=1, then go to WRITEBACK.
  - mem_ready is ignored in every other state.
- WRITEBACK: reg_write=1. reg_dst_rt=1 for ADDI/LW, else 0. mem_to_reg=1 for LW only. Increment retired, go to FETCH.
- TRAP: trap=1, all strobes 0, stays until reset. run has no effect.
- Retired counter saturates at 2^CNT_W-1 and never wraps.
- Strobes are pure decode of state plus latched class; none are registered. Latency per class:
  - J: 2 cycles.
  - BEQ: 3 cycles.
  - SW: 4 + wait cycles.
  - ADD/SUB/ADDI: 4 cycles.
  - LW: 5 + wait cycles.
- Reset asserted mid-instruction aborts immediately; no write strobe is asserted in the reset cycle.

Decomposition:
- Package mips_pkg holds:
  - state encodings (ST_RESET..ST_TRAP)
  - opcode/funct constants (OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, OP_LW, OP_SW, FN_ADD, FN_SUB)
  - instruction-class enum
  - pc_src and alu_op encodings
- One natural sub-module, mips_ctrl_decode: combinational opcode/funct to class plus illegal flag. The state register, output decode and counter stay in mips_multi_ctrl.

Test Plan:
- Reset then run=1; ADD (op 0, funct 0x20). Required states: 1,2,3,4,6,2. reg_write=1 only in state 6 with reg_dst_rt=0. retired goes 0 to 1.
- LW (op 0x23) with mem_ready low for 3 cycles. Required: MEMORY held 4 cycles with mem_wren=0, then WRITEBACK with mem_to_reg=1 and reg_dst_rt=1. Total 8 cycles FETCH to FETCH.
- SW (op 0x2B), mem_ready=1 immediately. Required: mem_wren=1 for exactly 1 cycle, no WRITEBACK, retired increments once.
- BEQ with zero=1, then BEQ with zero=0. Required: pc_write=1/pc_src=1 in EXECUTE for the first, pc_write=0 for the second. Both return to FETCH after 3 cycles.
- J (op 0x02). Required: DECODE asserts pc_write=1, pc_src=2. Next state is FETCH; EXECUTE is never entered.
- Two remaining cases:
  - Opcode 0x3F: state 7, trap=1, sticky through run toggles, cleared only by rst_n=0.
  - Drop run during an ADD: the ADD completes, then the FSM enters HALT with no ir_write.
